// File: rtl/tlb_pkg.sv
// Shared types and constants for the LoongArch TLB lookup slice.
// Optional build macro: TLB_HUGE_PAGE_EN (honour entry PS for 2 MB pages).
package tlb_pkg;

  localparam logic [1:0] FETCH = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] STORE = 2'b10;

  localparam logic [4:0] INV_ALL        = 5'd0;
  localparam logic [4:0] INV_ALL_ALT    = 5'd1;
  localparam logic [4:0] INV_GLOBAL     = 5'd2;
  localparam logic [4:0] INV_PRIVATE    = 5'd3;
  localparam logic [4:0] INV_ASID       = 5'd4;
  localparam logic [4:0] INV_ASID_VA    = 5'd5;
  localparam logic [4:0] INV_VISIBLE_VA = 5'd6;
  localparam logic [4:0] INV_OP_MAX     = 5'd6;

  localparam logic [5:0] PS_4K   = 6'd12;
  localparam logic [5:0] PS_HUGE = 6'd21;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } phytran_item;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    phytran_item phytran0;
    phytran_item phytran1;
  } tlb_entry_t;

  // Which G/ASID combination an entry must satisfy to count as a hit.
  typedef enum logic [2:0] {
    SCOPE_ANY,
    SCOPE_GLOBAL,
    SCOPE_PRIVATE,
    SCOPE_ASID,
    SCOPE_VISIBLE
  } scope_e;

  typedef struct packed {
    logic   check_e;
    logic   check_va;
    scope_e scope;
  } match_mode_t;

  typedef enum logic [1:0] {
    INV_IDLE,
    INV_WALK,
    INV_DONE
  } inv_state_e;

  localparam match_mode_t SEARCH_MODE = '{check_e: 1'b1, check_va: 1'b1, scope: SCOPE_VISIBLE};

  // INVTLB op code -> match mode; E is not checked since clearing a clear E is harmless.
  function automatic match_mode_t inv_mode(input logic [4:0] op);
    match_mode_t m;
    m = '{check_e: 1'b0, check_va: 1'b0, scope: SCOPE_ANY};
    case (op)
      INV_GLOBAL:     m.scope = SCOPE_GLOBAL;
      INV_PRIVATE:    m.scope = SCOPE_PRIVATE;
      INV_ASID:       m.scope = SCOPE_ASID;
      INV_ASID_VA:    begin m.scope = SCOPE_ASID;    m.check_va = 1'b1; end
      INV_VISIBLE_VA: begin m.scope = SCOPE_VISIBLE; m.check_va = 1'b1; end
      default:        m.scope = SCOPE_ANY;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Compares one TLB entry against a request (VPN + ASID) under a match mode.
// Optional build macro: TLB_HUGE_PAGE_EN (PS==21 compares only VPPN[18:9]).
module tlb_entry_match
  import tlb_pkg::*;
(
  input  logic        e,
  input  logic        g,
  input  logic [9:0]  entry_asid,
  input  logic [18:0] vppn,
  input  logic [5:0]  ps,
  input  logic [18:0] vpn,
  input  logic [9:0]  asid,
  input  match_mode_t mode,
  output logic        hit
);

  logic va_match;
  logic asid_match;
  logic scope_ok;

`ifndef TLB_HUGE_PAGE_EN
  logic unused_ps;
  assign unused_ps = ^ps;
`endif

  // Hit = enable gate & scope gate & VA gate, each gate optional via mode.
  always_comb begin
    asid_match = (entry_asid == asid);
`ifdef TLB_HUGE_PAGE_EN
    va_match = (ps == PS_HUGE) ? (vpn[18:9] == vppn[18:9]) : (vpn == vppn);
`else
    va_match = (vpn == vppn);
`endif
    case (mode.scope)
      SCOPE_ANY:     scope_ok = 1'b1;
      SCOPE_GLOBAL:  scope_ok = g;
      SCOPE_PRIVATE: scope_ok = ~g;
      SCOPE_ASID:    scope_ok = ~g & asid_match;
      SCOPE_VISIBLE: scope_ok = g | asid_match;
      default:       scope_ok = 1'b0;
    endcase
    hit = (e | ~mode.check_e) & scope_ok & (va_match | ~mode.check_va);
  end

endmodule

// File: rtl/tlb_lookup.sv
// Fully-associative TLB array with a registered search port, a write port
// and an INVTLB walker (one entry per cycle).
// Optional build macro: TLB_HUGE_PAGE_EN (2 MB pages via entry PS).
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_vaddr,
  input  logic [1:0]        s_memtype,
  input  logic [9:0]        s_asid,
  output logic              r_valid,
  output logic [IDXW-1:0]   r_index,
  output logic [1:0]        TLB_memtype,
  output logic [9:0]        TLB_s1_ASID,
  output logic [31:0]       TLB_virtaddr,
  output logic              TLB_s1_NE,
  output logic              TLB_s1_G,
  output phytran_item       TLB_s1_phytran0,
  output phytran_item       TLB_s1_phytran1,
  input  logic              w_en,
  input  logic [IDXW-1:0]   w_index,
  input  tlb_entry_t        w_entry,
  input  logic              inv_start,
  input  logic [4:0]        inv_op,
  input  logic [9:0]        inv_asid,
  input  logic [31:0]       inv_va,
  output logic              inv_done,
  output logic              inv_err
);

  tlb_entry_t        tlb [TLBNUM];
  logic [TLBNUM-1:0] entry_e;
  logic [TLBNUM-1:0] s_hit;
  logic [IDXW-1:0]   hit_idx;
  logic              hit_any;
  logic [31:0]       virt_next;

  inv_state_e        state, state_next;
  logic [IDXW-1:0]   walk_idx;
  logic [4:0]        inv_op_q;
  logic [9:0]        inv_asid_q;
  logic [18:0]       inv_vpn_q;
  logic              inv_err_q;
  logic              walk_hit;

  logic              accept;
  logic              w_fire;

  logic unused_inv_va;
  assign unused_inv_va = ^inv_va[12:0];

  assign s_ready = (state == INV_IDLE);
  assign accept  = s_valid & s_ready;
  assign w_fire  = w_en & s_ready;

  // E bits live in a flat vector so reset and walker clears touch only them.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_e <= '0;
    end else if (w_fire) begin
      entry_e[w_index] <= w_entry.e;
    end else if (state == INV_WALK && walk_hit) begin
      entry_e[walk_idx] <= 1'b0;
    end
  end

  // Entry payload storage; not reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      tlb[w_index] <= w_entry;
    end
  end

  for (genvar i = 0; i < TLBNUM; i++) begin : g_search
    tlb_entry_match u_match (
      .e          (entry_e[i]),
      .g          (tlb[i].g),
      .entry_asid (tlb[i].asid),
      .vppn       (tlb[i].vppn),
      .ps         (tlb[i].ps),
      .vpn        (s_vaddr[31:13]),
      .asid       (s_asid),
      .mode       (SEARCH_MODE),
      .hit        (s_hit[i])
    );
  end

  tlb_entry_match u_walk_match (
    .e          (entry_e[walk_idx]),
    .g          (tlb[walk_idx].g),
    .entry_asid (tlb[walk_idx].asid),
    .vppn       (tlb[walk_idx].vppn),
    .ps         (tlb[walk_idx].ps),
    .vpn        (inv_vpn_q),
    .asid       (inv_asid_q),
    .mode       (inv_mode(inv_op_q)),
    .hit        (walk_hit)
  );

  // Lowest-index hit wins.
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (s_hit[i] && !hit_any) begin
        hit_idx = IDXW'(i);
        hit_any = 1'b1;
      end
    end
  end

  // Registered VA; for a huge-page hit, bit 12 carries the odd/even selector vaddr[21].
  always_comb begin
    virt_next = s_vaddr;
`ifdef TLB_HUGE_PAGE_EN
    if (hit_any && tlb[hit_idx].ps == PS_HUGE) begin
      virt_next[12] = s_vaddr[21];
    end
`endif
  end

  // Search result register: loads on accept, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid         <= 1'b0;
      r_index         <= '0;
      TLB_memtype     <= '0;
      TLB_s1_ASID     <= '0;
      TLB_virtaddr    <= '0;
      TLB_s1_NE       <= 1'b0;
      TLB_s1_G        <= 1'b0;
      TLB_s1_phytran0 <= '0;
      TLB_s1_phytran1 <= '0;
    end else begin
      r_valid <= accept;
      if (accept) begin
        r_index         <= hit_idx;
        TLB_memtype     <= s_memtype;
        TLB_s1_ASID     <= s_asid;
        TLB_virtaddr    <= virt_next;
        TLB_s1_NE       <= ~hit_any;
        TLB_s1_G        <= hit_any & tlb[hit_idx].g;
        TLB_s1_phytran0 <= hit_any ? tlb[hit_idx].phytran0 : '0;
        TLB_s1_phytran1 <= hit_any ? tlb[hit_idx].phytran1 : '0;
      end
    end
  end

  // INVTLB state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // INVTLB operand latch and walk index.
  always_ff @(posedge clk) begin
    if (reset) begin
      walk_idx   <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vpn_q  <= '0;
      inv_err_q  <= 1'b0;
    end else if (state == INV_IDLE) begin
      walk_idx <= '0;
      if (inv_start) begin
        inv_op_q   <= inv_op;
        inv_asid_q <= inv_asid;
        inv_vpn_q  <= inv_va[31:13];
        inv_err_q  <= (inv_op > INV_OP_MAX);
      end
    end else if (state == INV_WALK) begin
      walk_idx <= walk_idx + 1'b1;
    end
  end

  // INVTLB next-state and done/err outputs.
  always_comb begin
    state_next = state;
    inv_done   = 1'b0;
    inv_err    = 1'b0;
    case (state)
      INV_IDLE: begin
        if (inv_start) begin
          state_next = (inv_op > INV_OP_MAX) ? INV_DONE : INV_WALK;
        end
      end
      INV_WALK: begin
        if (walk_idx == IDXW'(TLBNUM - 1)) begin
          state_next = INV_DONE;
        end
      end
      INV_DONE: begin
        inv_done   = 1'b1;
        inv_err    = inv_err_q;
        state_next = INV_IDLE;
      end
      default: state_next = INV_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_lookup.sv
// Directed self-checking bench for tlb_lookup (default build, 16 entries).
module tb_tlb_lookup;
  import tlb_pkg::*;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = 4;

  logic            clk;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [31:0]     s_vaddr;
  logic [1:0]      s_memtype;
  logic [9:0]      s_asid;
  logic            r_valid;
  logic [IDXW-1:0] r_index;
  logic [1:0]      TLB_memtype;
  logic [9:0]      TLB_s1_ASID;
  logic [31:0]     TLB_virtaddr;
  logic            TLB_s1_NE;
  logic            TLB_s1_G;
  phytran_item     TLB_s1_phytran0;
  phytran_item     TLB_s1_phytran1;
  logic            w_en;
  logic [IDXW-1:0] w_index;
  tlb_entry_t      w_entry;
  logic            inv_start;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [31:0]     inv_va;
  logic            inv_done;
  logic            inv_err;

  int n_chk = 0;
  int n_bad = 0;

  tlb_lookup #(.TLBNUM(TLBNUM)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_vaddr         (s_vaddr),
    .s_memtype       (s_memtype),
    .s_asid          (s_asid),
    .r_valid         (r_valid),
    .r_index         (r_index),
    .TLB_memtype     (TLB_memtype),
    .TLB_s1_ASID     (TLB_s1_ASID),
    .TLB_virtaddr    (TLB_virtaddr),
    .TLB_s1_NE       (TLB_s1_NE),
    .TLB_s1_G        (TLB_s1_G),
    .TLB_s1_phytran0 (TLB_s1_phytran0),
    .TLB_s1_phytran1 (TLB_s1_phytran1),
    .w_en            (w_en),
    .w_index         (w_index),
    .w_entry         (w_entry),
    .inv_start       (inv_start),
    .inv_op          (inv_op),
    .inv_asid        (inv_asid),
    .inv_va          (inv_va),
    .inv_done        (inv_done),
    .inv_err         (inv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic phytran_item mk_pt(input logic [19:0] ppn, input logic [1:0] plv);
    phytran_item p;
    p.ppn = ppn;
    p.plv = plv;
    p.mat = 2'd1;
    p.d   = 1'b1;
    p.v   = 1'b1;
    return p;
  endfunction

  function automatic tlb_entry_t mk_entry(input logic [18:0] vppn, input logic [9:0] asid,
                                          input logic g, input logic [19:0] ppn0,
                                          input logic [19:0] ppn1);
    tlb_entry_t t;
    t.vppn     = vppn;
    t.ps       = PS_4K;
    t.g        = g;
    t.asid     = asid;
    t.e        = 1'b1;
    t.phytran0 = mk_pt(ppn0, 2'd0);
    t.phytran1 = mk_pt(ppn1, 2'd3);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic search(input logic [31:0] va, input logic [9:0] asid, input logic [1:0] mt);
    s_valid   = 1'b1;
    s_vaddr   = va;
    s_asid    = asid;
    s_memtype = mt;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic write(input logic [IDXW-1:0] idx, input tlb_entry_t ent);
    w_en    = 1'b1;
    w_index = idx;
    w_entry = ent;
    tick();
    w_en = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [IDXW-1:0] idx);
    check({tag, "_rvalid"}, 64'(r_valid), 64'd1);
    check({tag, "_ne"}, 64'(TLB_s1_NE), 64'd0);
    check({tag, "_index"}, 64'(r_index), 64'(idx));
  endtask

  task automatic expect_miss(input string tag);
    check({tag, "_rvalid"}, 64'(r_valid), 64'd1);
    check({tag, "_ne"}, 64'(TLB_s1_NE), 64'd1);
    check({tag, "_index"}, 64'(r_index), 64'd0);
    check({tag, "_pt0"}, 64'(TLB_s1_phytran0), 64'd0);
    check({tag, "_pt1"}, 64'(TLB_s1_phytran1), 64'd0);
    check({tag, "_g"}, 64'(TLB_s1_G), 64'd0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic err_seen;

    reset     = 1'b1;
    s_valid   = 1'b0;
    s_vaddr   = '0;
    s_memtype = '0;
    s_asid    = '0;
    w_en      = 1'b0;
    w_index   = '0;
    w_entry   = '0;
    inv_start = 1'b0;
    inv_op    = '0;
    inv_asid  = '0;
    inv_va    = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_rvalid", 64'(r_valid), 64'd0);
    check("rst_ne", 64'(TLB_s1_NE), 64'd0);
    check("rst_va", 64'(TLB_virtaddr), 64'd0);
    check("rst_done", 64'(inv_done), 64'd0);
    check("rst_err", 64'(inv_err), 64'd0);

    // 1: search on empty TLB
    search(32'h0040_0000, 10'd0, LOAD);
    expect_miss("t1");
    check("t1_va", 64'(TLB_virtaddr), 64'h0040_0000);
    check("t1_mt", 64'(TLB_memtype), 64'(LOAD));
    tick();
    check("t1_rvalid_drop", 64'(r_valid), 64'd0);
    check("t1_ne_hold", 64'(TLB_s1_NE), 64'd1);

    // 2: ASID-private entry at index 3
    write(4'd3, mk_entry(19'h00200, 10'd5, 1'b0, 20'h11111, 20'h22222));
    search(32'h0040_1000, 10'd5, STORE);
    expect_hit("t2", 4'd3);
    check("t2_pt1", 64'(TLB_s1_phytran1), 64'(mk_pt(20'h22222, 2'd3)));
    check("t2_pt0", 64'(TLB_s1_phytran0), 64'(mk_pt(20'h11111, 2'd0)));
    check("t2_g", 64'(TLB_s1_G), 64'd0);
    check("t2_asid", 64'(TLB_s1_ASID), 64'd5);
    check("t2_va", 64'(TLB_virtaddr), 64'h0040_1000);
    check("t2_mt", 64'(TLB_memtype), 64'(STORE));
    search(32'h0040_1000, 10'd6, LOAD);
    expect_miss("t2_asid6");

    // 3: two global entries match, lowest index wins
    write(4'd7, mk_entry(19'h00300, 10'd9, 1'b1, 20'h00007, 20'h00077));
    write(4'd2, mk_entry(19'h00300, 10'd8, 1'b1, 20'h00002, 20'h00022));
    search(32'h0060_0000, 10'd3, FETCH);
    expect_hit("t3", 4'd2);
    check("t3_g", 64'(TLB_s1_G), 64'd1);
    check("t3_pt0", 64'(TLB_s1_phytran0), 64'(mk_pt(20'h00002, 2'd0)));

    // 4: write and search in the same cycle sees old contents
    w_en      = 1'b1;
    w_index   = 4'd1;
    w_entry   = mk_entry(19'h00400, 10'd5, 1'b0, 20'h00001, 20'h00011);
    s_valid   = 1'b1;
    s_vaddr   = 32'h0080_0000;
    s_asid    = 10'd5;
    s_memtype = LOAD;
    tick();
    w_en    = 1'b0;
    s_valid = 1'b0;
    expect_miss("t4_same");
    search(32'h0080_0000, 10'd5, LOAD);
    expect_hit("t4_next", 4'd1);

    write(4'd4, mk_entry(19'h00500, 10'd6, 1'b0, 20'h00004, 20'h00044));

    // 5: INVTLB op4 ASID5; a second start mid-walk must be ignored
    inv_start = 1'b1;
    inv_op    = INV_ASID;
    inv_asid  = 10'd5;
    inv_va    = '0;
    tick();
    inv_start = 1'b0;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_at   = 0;
    err_seen  = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (!s_ready) busy_cnt++;
      if (inv_done) begin
        done_cnt++;
        done_at  = k;
        err_seen = inv_err;
      end
      inv_start = (k == 3);
      inv_op    = (k == 3) ? INV_ALL : INV_ASID;
      tick();
    end
    inv_start = 1'b0;
    check("t5_busy_cycles", 64'(busy_cnt), 64'd17);
    check("t5_done_count", 64'(done_cnt), 64'd1);
    check("t5_done_at", 64'(done_at), 64'd17);
    check("t5_err", 64'(err_seen), 64'd0);
    search(32'h0080_0000, 10'd5, LOAD);
    expect_miss("t5_idx1");
    search(32'h0040_1000, 10'd5, LOAD);
    expect_miss("t5_idx3");
    search(32'h0060_0000, 10'd5, LOAD);
    expect_hit("t5_global", 4'd2);
    search(32'h00A0_0000, 10'd6, LOAD);
    expect_hit("t5_asid6", 4'd4);

    // 5b: illegal op -> immediate done with err, nothing cleared
    inv_start = 1'b1;
    inv_op    = 5'd9;
    tick();
    inv_start = 1'b0;
    check("t5b_done", 64'(inv_done), 64'd1);
    check("t5b_err", 64'(inv_err), 64'd1);
    check("t5b_ready", 64'(s_ready), 64'd0);
    tick();
    check("t5b_done_drop", 64'(inv_done), 64'd0);
    check("t5b_ready_back", 64'(s_ready), 64'd1);
    search(32'h00A0_0000, 10'd6, LOAD);
    expect_hit("t5b_kept", 4'd4);

    // 6: reset during walk cycle 5 aborts without done
    inv_start = 1'b1;
    inv_op    = INV_ALL;
    tick();
    inv_start = 1'b0;
    repeat (4) tick();
    check("t6_busy_before", 64'(s_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_ready", 64'(s_ready), 64'd1);
    check("t6_done", 64'(inv_done), 64'd0);
    check("t6_rvalid", 64'(r_valid), 64'd0);
    done_cnt = 0;
    repeat (20) begin
      if (inv_done) done_cnt++;
      tick();
    end
    check("t6_no_done", 64'(done_cnt), 64'd0);
    search(32'h0060_0000, 10'd0, LOAD);
    expect_miss("t6_idx7");
    search(32'h00A0_0000, 10'd6, LOAD);
    expect_miss("t6_idx4");
    search(32'h0040_1000, 10'd5, LOAD);
    expect_miss("t6_idx3");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
